// File: rtl/get_param_pkg.sv
// Shared types and constants for the get_param_bt backtracking parameter fetcher.
// State-word layout, LSB first: over flag, back_addr, position.
package get_param_pkg;

  localparam int unsigned DEF_PW        = 8;
  localparam int unsigned DEF_AW        = 12;
  localparam int unsigned DEF_POSW      = 5;
  localparam int unsigned DEF_MAX_HOPS  = 16;
  localparam int unsigned DEF_ROOT_ADDR = 0;

  localparam int unsigned OVER_BIT = 0;
  localparam int unsigned BACK_LSB = 1;
  localparam int unsigned POS_LSB  = BACK_LSB + DEF_AW;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EVAL   = 3'd2,
    S_OUT    = 3'd3,
    S_FINISH = 3'd4
  } state_e;

endpackage

// File: rtl/get_param_bt.sv
// Walks the back_addr chain of the InexRecur/state regfiles until a node with over=0
// is found, the root is reached, or the hop budget runs out; presents the result on a valid/ready port.
module get_param_bt
  import get_param_pkg::*;
#(
  parameter int unsigned PW        = DEF_PW,
  parameter int unsigned AW        = DEF_AW,
  parameter int unsigned POSW      = DEF_POSW,
  parameter int unsigned MAX_HOPS  = DEF_MAX_HOPS,
  parameter int unsigned ROOT_ADDR = DEF_ROOT_ADDR
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              abort,
  output logic                              busy,
  output logic                              rd_en,
  output logic                              rd_seq,
  output logic [AW-1:0]                     rd_addr,
  input  logic [AW-1:0]                     param_addr_i,
  input  logic [4*PW-1:0]                   param_data_i,
  input  logic [POSW+AW:0]                  state_data_i,
  output logic                              o_valid,
  input  logic                              o_ready,
  output logic [PW-1:0]                     i_out,
  output logic [PW-1:0]                     z_out,
  output logic [PW-1:0]                     k_out,
  output logic [PW-1:0]                     l_out,
  output logic [AW-1:0]                     addr_out,
  output logic [POSW-1:0]                   position_out,
  output logic                              is_find,
  output logic                              exhausted,
  output logic                              hop_err,
  output logic [$clog2(MAX_HOPS+1)-1:0]     hop_cnt
);

  localparam int unsigned HCW     = $clog2(MAX_HOPS + 1);
  localparam logic [HCW-1:0] HOP_LIM = HCW'(MAX_HOPS);
  // position sits directly above back_addr whatever AW is chosen
  localparam int unsigned POS_OFF = POS_LSB - DEF_AW + AW;

  state_e          r_state;
  logic            w_over;
  logic            w_root;
  logic [AW-1:0]   w_back;
  logic [POSW-1:0] w_pos;

  assign w_over = state_data_i[OVER_BIT];
  assign w_back = state_data_i[BACK_LSB +: AW];
  assign w_pos  = state_data_i[POS_OFF +: POSW];
  assign w_root = (param_addr_i == AW'(ROOT_ADDR));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      busy         <= 1'b0;
      rd_en        <= 1'b0;
      rd_seq       <= 1'b0;
      rd_addr      <= '0;
      o_valid      <= 1'b0;
      i_out        <= '0;
      z_out        <= '0;
      k_out        <= '0;
      l_out        <= '0;
      addr_out     <= '0;
      position_out <= '0;
      is_find      <= 1'b0;
      exhausted    <= 1'b0;
      hop_err      <= 1'b0;
      hop_cnt      <= '0;
    end else if (abort) begin
      r_state   <= S_IDLE;
      busy      <= 1'b0;
      rd_en     <= 1'b0;
      o_valid   <= 1'b0;
      is_find   <= 1'b0;
      exhausted <= 1'b0;
      hop_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_FETCH;
            busy      <= 1'b1;
            rd_en     <= 1'b1;
            rd_seq    <= 1'b1;
            hop_cnt   <= '0;
            is_find   <= 1'b0;
            exhausted <= 1'b0;
            hop_err   <= 1'b0;
          end
        end
        S_FETCH: begin
          rd_en   <= 1'b0;
          r_state <= S_EVAL;
        end
        S_EVAL: begin
          if (!w_over) begin
            i_out        <= param_data_i[4*PW-1 -: PW];
            z_out        <= param_data_i[3*PW-1 -: PW];
            k_out        <= param_data_i[2*PW-1 -: PW];
            l_out        <= param_data_i[PW-1:0];
            addr_out     <= param_addr_i;
            position_out <= w_pos;
            is_find      <= 1'b1;
            o_valid      <= 1'b1;
            r_state      <= S_OUT;
          end else if (w_root) begin
            exhausted <= 1'b1;
            is_find   <= 1'b0;
            o_valid   <= 1'b1;
            r_state   <= S_FINISH;
          end else if (hop_cnt == HOP_LIM) begin
            hop_err <= 1'b1;
            is_find <= 1'b0;
            o_valid <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            // hop_cnt < HOP_LIM here, so the increment saturates at the limit
            rd_addr <= w_back;
            rd_seq  <= 1'b0;
            rd_en   <= 1'b1;
            hop_cnt <= hop_cnt + HCW'(1);
            r_state <= S_FETCH;
          end
        end
        S_OUT, S_FINISH: begin
          if (o_ready) begin
            o_valid <= 1'b0;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          rd_en   <= 1'b0;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_get_param_bt.sv
// Scoreboard bench for get_param_bt: a regfile model answers reads, a monitor checks every result.
module tb_get_param_bt;

  localparam int PW = 8, AW = 12, POSW = 5, MH = 4, HCW = $clog2(MH + 1);

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, o_ready = 1'b1;
  logic busy, rd_en, rd_seq, o_valid, is_find, exhausted, hop_err;
  logic [AW-1:0] rd_addr, addr_out;
  logic [PW-1:0] i_out, z_out, k_out, l_out;
  logic [POSW-1:0] position_out;
  logic [HCW-1:0] hop_cnt;
  logic [AW-1:0] param_addr_i = '0;
  logic [4*PW-1:0] param_data_i = '0;
  logic [POSW+AW:0] state_data_i = '0;

  logic [4*PW-1:0]  mem_d [0:4095];
  logic [POSW+AW:0] mem_s [0:4095];
  logic [AW-1:0]    seq_addr = '0;
  logic [AW:0]      log_q [$];
  int cyc = 0, fetch_cnt = 0;
  int errors = 0, checks = 0;

  typedef struct {
    logic chk_data;
    logic [PW-1:0] i, z, k, l;
    logic [AW-1:0] addr;
    logic [POSW-1:0] pos;
    logic fnd, exh, herr;
    logic [HCW-1:0] hops;
    int start_cyc;
    int lat;
  } exp_t;
  exp_t sb [$];

  get_param_bt #(.MAX_HOPS(MH)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy),
    .rd_en(rd_en), .rd_seq(rd_seq), .rd_addr(rd_addr),
    .param_addr_i(param_addr_i), .param_data_i(param_data_i), .state_data_i(state_data_i),
    .o_valid(o_valid), .o_ready(o_ready),
    .i_out(i_out), .z_out(z_out), .k_out(k_out), .l_out(l_out),
    .addr_out(addr_out), .position_out(position_out),
    .is_find(is_find), .exhausted(exhausted), .hop_err(hop_err), .hop_cnt(hop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // regfile model: one-cycle read latency, sequential reads start at seq_addr
  always @(posedge clk) begin
    if (rd_en) begin
      param_addr_i <= rd_seq ? seq_addr : rd_addr;
      param_data_i <= mem_d[rd_seq ? seq_addr : rd_addr];
      state_data_i <= mem_s[rd_seq ? seq_addr : rd_addr];
      fetch_cnt    <= fetch_cnt + 1;
      log_q.push_back({rd_seq, rd_seq ? seq_addr : rd_addr});
    end
  end

  function automatic logic [POSW+AW:0] sw(input logic [POSW-1:0] pos, input logic [AW-1:0] back,
                                          input logic over);
    return {pos, back, over};
  endfunction

  function automatic logic [127:0] res_word();
    return {72'd0, i_out, z_out, k_out, l_out, addr_out, position_out, is_find, exhausted, hop_err, hop_cnt};
  endfunction

  function automatic logic [127:0] all_outs();
    return {57'd0, busy, rd_en, rd_seq, rd_addr, o_valid, i_out, z_out, k_out, l_out,
            addr_out, position_out, is_find, exhausted, hop_err, hop_cnt};
  endfunction

  function automatic exp_t mk(input logic cd, input logic [4*PW-1:0] d, input logic [AW-1:0] a,
                              input logic [POSW-1:0] p, input logic f, input logic ex,
                              input logic he, input logic [HCW-1:0] h, input int lat);
    exp_t e;
    e.chk_data = cd;
    {e.i, e.z, e.k, e.l} = d;
    e.addr = a; e.pos = p; e.fnd = f; e.exh = ex; e.herr = he; e.hops = h;
    e.start_cyc = 0; e.lat = lat;
    return e;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_search(input logic [AW-1:0] a, input exp_t e);
    seq_addr = a;
    start = 1'b1;
    e.start_cyc = cyc;
    sb.push_back(e);
    tick();
    start = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100; n++) begin
      if (sb.size() == 0) break;
      tick();
    end
    check("drain_timeout", 128'(sb.size()), 128'd0);
    sb.delete();
  endtask

  // monitor: snapshot on o_valid rise, require stability, compare at handshake
  logic mon_prev = 1'b0;
  int vcyc = 0;
  logic [127:0] snap = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_valid && !mon_prev) begin
        vcyc = cyc;
        snap = res_word();
      end else if (o_valid) begin
        check("hold_stable", res_word(), snap);
      end
      if (o_valid && o_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 128'd1, 128'd0);
        end else begin
          e = sb.pop_front();
          check("latency", 128'(vcyc - e.start_cyc), 128'(e.lat));
          check("flags", {125'd0, is_find, exhausted, hop_err}, {125'd0, e.fnd, e.exh, e.herr});
          check("hop_cnt", 128'(hop_cnt), 128'(e.hops));
          if (e.chk_data) begin
            check("data", {96'd0, i_out, z_out, k_out, l_out}, {96'd0, e.i, e.z, e.k, e.l});
            check("addr_pos", {111'd0, addr_out, position_out}, {111'd0, e.addr, e.pos});
          end
        end
      end
      mon_prev = o_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int li, fc;
    for (int a = 0; a < 4096; a++) begin
      mem_d[a] = '0;
      mem_s[a] = '0;
    end
    mem_d[5]  = 32'h01020304; mem_s[5]  = sw(5'd3, 12'd0, 1'b0);
    mem_s[9]  = sw(5'd0, 12'd6, 1'b1);
    mem_s[6]  = sw(5'd0, 12'd2, 1'b1);
    mem_d[2]  = 32'hA1B2C3D4; mem_s[2]  = sw(5'd7, 12'd0, 1'b0);
    mem_s[11] = sw(5'd0, 12'd0, 1'b1);
    mem_s[0]  = sw(5'd0, 12'd0, 1'b1);
    mem_s[20] = sw(5'd0, 12'd21, 1'b1);
    mem_s[21] = sw(5'd0, 12'd22, 1'b1);
    mem_s[22] = sw(5'd0, 12'd23, 1'b1);
    mem_s[23] = sw(5'd0, 12'd20, 1'b1);
    mem_d[30] = 32'h55667788; mem_s[30] = sw(5'd17, 12'd0, 1'b0);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", all_outs(), 128'd0);
    rst = 1'b0;
    tick();

    // no hop
    run_search(12'd5, mk(1'b1, 32'h01020304, 12'd5, 5'd3, 1'b1, 1'b0, 1'b0, 3'd0, 3));
    drain();

    // two hops via 9 -> 6 -> 2
    li = log_q.size();
    run_search(12'd9, mk(1'b1, 32'hA1B2C3D4, 12'd2, 5'd7, 1'b1, 1'b0, 1'b0, 3'd2, 7));
    drain();
    check("two_hop_fetches", 128'(log_q.size() - li), 128'd3);
    if (log_q.size() >= li + 3) begin
      check("fetch0_seq", 128'(log_q[li][AW]), 128'd1);
      check("fetch1_rand", 128'(log_q[li+1]), {115'd0, 1'b0, 12'd6});
      check("fetch2_rand", 128'(log_q[li+2]), {115'd0, 1'b0, 12'd2});
    end

    // chain reaches root with over=1
    run_search(12'd11, mk(1'b0, 32'd0, 12'd0, 5'd0, 1'b0, 1'b1, 1'b0, 3'd1, 5));
    drain();

    // endless loop avoiding root: hop limit
    fc = fetch_cnt;
    run_search(12'd20, mk(1'b0, 32'd0, 12'd0, 5'd0, 1'b0, 1'b0, 1'b1, 3'd4, 11));
    drain();
    check("hop_limit_fetches", 128'(fetch_cnt - fc), 128'd5);

    // backpressure, then start coinciding with o_ready in OUT
    o_ready = 1'b0;
    run_search(12'd30, mk(1'b1, 32'h55667788, 12'd30, 5'd17, 1'b1, 1'b0, 1'b0, 3'd0, 3));
    for (int n = 0; n < 20; n++) begin
      if (o_valid) break;
      tick();
    end
    check("bp_valid_seen", 128'(o_valid), 128'd1);
    repeat (10) tick();
    check("bp_still_valid", 128'(o_valid), 128'd1);
    fc = fetch_cnt;
    start = 1'b1;
    o_ready = 1'b1;
    tick();
    start = 1'b0;
    check("bp_idle", {125'd0, busy, o_valid, rd_en}, 128'd0);
    tick();
    check("start_ignored", {125'd0, busy, rd_en, 1'b0}, 128'd0);
    check("start_no_fetch", 128'(fetch_cnt - fc), 128'd0);
    check("bp_drained", 128'(sb.size()), 128'd0);
    sb.delete();

    // abort while in EVAL
    seq_addr = 12'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_ctrl", {125'd0, busy, o_valid, rd_en}, 128'd0);
    check("abort_flags", {125'd0, is_find, exhausted, hop_err}, 128'd0);
    fc = fetch_cnt;
    repeat (5) tick();
    check("abort_quiet", {126'd0, o_valid, busy}, 128'd0);
    check("abort_no_fetch", 128'(fetch_cnt - fc), 128'd0);

    // async reset pulse during FETCH
    seq_addr = 12'd5;
    fc = fetch_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rst_pre_rden", 128'(rd_en), 128'd1);
    #2 rst = 1'b1;
    #1 check("rst_async_outs", all_outs(), 128'd0);
    #1 rst = 1'b0;
    repeat (4) tick();
    check("rst_idle", {125'd0, busy, rd_en, o_valid}, 128'd0);
    check("rst_no_fetch", 128'(fetch_cnt - fc), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/get_param_bt.md
GET_PARAM_BT -- requirements
Module: get_param_bt

Interface
REQ-001 Parameters SHALL be: PW=8 (width of each of i/z/k/l); AW=12 (regfile address width); POSW=5 (position width); MAX_HOPS=16 (backtrack limit per search); ROOT_ADDR=0 (address of tree root).
REQ-002 Ports SHALL be: clk in 1, rising-edge clock; rst in 1, asynchronous active-high reset; one clock, no other clock domains.
REQ-003 Control ports SHALL be: start in 1, begin search; abort in 1, synchronous cancel; busy out 1, search in progress.
REQ-004 Regfile ports SHALL be: rd_en out 1, read strobe shared by InexRecur and state regfiles; rd_seq out 1, 1=sequential read, 0=random read at rd_addr; rd_addr out AW, random address; param_addr_i in AW, address of returned word; param_data_i in 4*PW, {i,z,k,l} MSB first; state_data_i in POSW+AW+1, {position, back_addr, over}.
REQ-005 Result ports SHALL be: o_valid out 1; o_ready in 1; i_out, z_out, k_out, l_out out PW each; addr_out out AW; position_out out POSW; is_find out 1; exhausted out 1; hop_err out 1; hop_cnt out clog2(MAX_HOPS+1).

Function
REQ-006 FSM states SHALL be IDLE, FETCH, EVAL, OUT, FINISH.
REQ-007 IDLE: busy=0, rd_en=0; start=1 -> FETCH with rd_seq=1, hop_cnt cleared, is_find/exhausted/hop_err cleared.
REQ-008 FETCH: rd_en=1 for exactly one cycle; rd_seq=1 on first fetch of a search, 0 on every backtrack fetch; rd_addr = registered back_addr (don't-care when rd_seq=1); -> EVAL.
REQ-009 Regfiles return data with fixed 1-cycle latency; EVAL SHALL sample param_data_i, param_addr_i, state_data_i in the cycle after FETCH.
REQ-010 EVAL with over=0: register i/z/k/l, addr_out=param_addr_i, position_out, is_find=1 -> OUT.
REQ-011 EVAL with over=1 and param_addr_i==ROOT_ADDR: exhausted=1, is_find=0 -> FINISH (root checked first).
REQ-012 EVAL with over=1, not root, hop_cnt==MAX_HOPS: hop_err=1 -> FINISH.
REQ-013 EVAL with over=1 otherwise: back_addr latched, hop_cnt+1 -> FETCH (random).
REQ-014 OUT: o_valid=1, all result outputs stable while o_ready=0; o_valid&o_ready -> IDLE, o_valid drops next cycle.
REQ-015 FINISH: o_valid=1 with is_find=0 and exhausted or hop_err set; handshake identical to OUT -> IDLE.
REQ-016 Latency: start at cycle 0 -> o_valid at cycle 3 with zero hops; each hop adds 2 cycles.
REQ-017 start outside IDLE SHALL be ignored; start and o_ready in same cycle in OUT completes handshake only.
REQ-018 abort SHALL force IDLE next cycle from any state, deassert o_valid and rd_en, clear flags; abort has priority over start, o_ready and EVAL decisions.
REQ-019 busy=1 in FETCH, EVAL, OUT, FINISH.
REQ-020 hop_cnt SHALL saturate at MAX_HOPS, never wrap.
REQ-021 All outputs SHALL be registered; no combinational path from regfile data inputs to any output.

Reset
REQ-022 rst=1 SHALL asynchronously force IDLE and all outputs to 0, including rd_en, rd_seq, rd_addr, o_valid, data, flags and hop_cnt.
REQ-023 Reset release mid-search SHALL leave the block in IDLE awaiting start; no pending read is reissued.

Structure
REQ-024 Package get_param_pkg SHALL hold FSM state enum, state-word field offsets (OVER_BIT, BACK_LSB, POS_LSB) and default parameter constants.
REQ-025 Single module, no sub-modules; field unpacking via package offsets.

Verification
REQ-026 No hop: start; regfile addr 5, data 0x01020304, state {pos=3, back=0, over=0} -> cycle 3 o_valid, i=1 z=2 k=3 l=4, addr_out=5, position_out=3, is_find=1, hop_cnt=0.
REQ-027 Two hops: addr 9 over=1 back=6; addr 6 over=1 back=2; addr 2 over=0 pos=7 -> rd_addr 6 then 2 with rd_seq=0, o_valid at cycle 7, addr_out=2, hop_cnt=2.
REQ-028 Root exhausted: chain ends at addr 0 with over=1 -> is_find=0, exhausted=1, o_valid=1.
REQ-029 Hop limit: MAX_HOPS=4, endless over=1 chain avoiding root -> exactly 5 fetches, hop_err=1, hop_cnt=4.
REQ-030 Backpressure/abort: o_ready low 10 cycles -> outputs stable; abort in EVAL -> IDLE next cycle, o_valid=0, no further rd_en.
REQ-031 Async reset: rst pulse between clock edges during FETCH -> rd_en=0 and all outputs 0 immediately, IDLE after release.
